ds18b20_temp_bcd: RTL and testbench

//  Downstream consumer of the DS18B20 1-Wire reader. Captures each 16-bit raw sample
//  (two's complement, 1/16 degC/LSB) on the UpDate rise and converts it to sign,
//  3 integer BCD digits and 1 tenths digit. Flags threshold alarms, out-of-range values
//  and the sensor power-on default (85 degC) for the display/alarm logic.

---
 rtl/ds18b20_temp_bcd.sv | 157 +++++++++++++++
 tb/tb_ds18b20_temp_bcd.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_temp_bcd.sv
// ds18b20_temp_bcd: converts raw DS18B20 samples to a sign, three integer BCD
// digits and a tenths digit. It also flags the high and low alarms, out-of-range
// readings and the sensor's 85 degC power-on value.
// Optional build macro TEMP_BCD_ROUND_EN selects round half-up for the tenths
// digit. Without it, the tenths digit is truncated.
module ds18b20_temp_bcd #(
  parameter logic signed [15:0] HI_LIMIT = 16'sh0500,
  parameter logic signed [15:0] LO_LIMIT = 16'shFC90
) (
  input  logic        Clk,
  input  logic        nRst,
  input  logic        UpDate,
  input  logic [15:0] Data,
  output logic [15:0] Raw,
  output logic        Sign,
  output logic [3:0]  BcdHund,
  output logic [3:0]  BcdTens,
  output logic [3:0]  BcdOnes,
  output logic [3:0]  BcdFrac,
  output logic        Valid,
  output logic        Busy,
  output logic        AlarmHi,
  output logic        AlarmLo,
  output logic        RangeErr,
  output logic        PorFlag
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  state_t      state, nextState;
  logic        upDateD;
  logic        rise;
  logic        load;
  logic [15:0] work;
  logic [15:0] pendData;
  logic        pendValid;
  logic [15:0] mag;
  logic [7:0]  fracProd;
  logic [19:0] sh;
  logic [3:0]  cnt;
  logic [3:0]  fracR;
  logic        rangeR;
  logic        firstFlag;

  // One double-dabble step: add 3 to each BCD digit >= 5, then shift left.
  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int unsigned i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  assign rise = UpDate & ~upDateD;
  // A sample starts a conversion from IDLE, or from DONE when one is waiting.
  // A rise coincident with DONE is the newest data, so it wins over pending.
  assign load = ((state == IDLE) && rise) || ((state == DONE) && (rise || pendValid));
  assign mag  = work[15] ? (16'd0 - work) : work;
`ifdef TEMP_BCD_ROUND_EN
  assign fracProd = ({4'd0, mag[3:0]} * 8'd10) + 8'd8;
`else
  assign fracProd = {4'd0, mag[3:0]} * 8'd10;
`endif
  assign Busy = (state != IDLE);

  // State register
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (rise) nextState = CONV;
      CONV:    if (cnt == 4'd8) nextState = DONE;
      DONE:    nextState = (rise || pendValid) ? CONV : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Edge detect, input capture and one-deep pending sample
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      upDateD   <= 1'b0;
      work      <= '0;
      pendData  <= '0;
      pendValid <= 1'b0;
    end else begin
      upDateD <= UpDate;
      if (load) begin
        work      <= rise ? Data : pendData;
        pendValid <= 1'b0;
      end else if (rise) begin
        pendData  <= Data;
        pendValid <= 1'b1;
      end
    end
  end

  // Conversion: the first CONV cycle loads magnitude and tenths; the next 8 run the dabble
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      cnt    <= '0;
      sh     <= '0;
      fracR  <= '0;
      rangeR <= 1'b0;
    end else if (state == CONV) begin
      if (cnt == 4'd0) begin
        sh     <= {12'd0, mag[11:4]};
        fracR  <= fracProd[7:4];
        rangeR <= |mag[15:12];
      end else begin
        sh <= dabble(sh);
      end
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end

  // Output registers, updated together with the one-cycle Valid pulse
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      Raw       <= '0;
      Sign      <= 1'b0;
      BcdHund   <= '0;
      BcdTens   <= '0;
      BcdOnes   <= '0;
      BcdFrac   <= '0;
      Valid     <= 1'b0;
      AlarmHi   <= 1'b0;
      AlarmLo   <= 1'b0;
      RangeErr  <= 1'b0;
      PorFlag   <= 1'b0;
      firstFlag <= 1'b1;
    end else begin
      Valid <= (state == DONE);
      if (state == DONE) begin
        Raw       <= work;
        Sign      <= work[15];
        BcdHund   <= rangeR ? 4'd9 : sh[19:16];
        BcdTens   <= rangeR ? 4'd9 : sh[15:12];
        BcdOnes   <= rangeR ? 4'd9 : sh[11:8];
        BcdFrac   <= rangeR ? 4'd9 : fracR;
        AlarmHi   <= $signed(work) >= HI_LIMIT;
        AlarmLo   <= $signed(work) <= LO_LIMIT;
        RangeErr  <= rangeR;
        PorFlag   <= firstFlag && (work == 16'h0550);
        firstFlag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_temp_bcd.sv
// Testbench for ds18b20_temp_bcd: directed literal checks plus randomized
// sample streams, compared every cycle against a timer-based reference model.
module tb_ds18b20_temp_bcd;

  logic        Clk = 1'b0;
  logic        nRst;
  logic        UpDate;
  logic [15:0] Data;
  logic [15:0] Raw;
  logic        Sign, Valid, Busy, AlarmHi, AlarmLo, RangeErr, PorFlag;
  logic [3:0]  BcdHund, BcdTens, BcdOnes, BcdFrac;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int riseCyc = 0;

  ds18b20_temp_bcd #(.HI_LIMIT(16'sh0500), .LO_LIMIT(16'shFC90)) dut (
    .Clk(Clk), .nRst(nRst), .UpDate(UpDate), .Data(Data), .Raw(Raw), .Sign(Sign),
    .BcdHund(BcdHund), .BcdTens(BcdTens), .BcdOnes(BcdOnes), .BcdFrac(BcdFrac),
    .Valid(Valid), .Busy(Busy), .AlarmHi(AlarmHi), .AlarmLo(AlarmLo),
    .RangeErr(RangeErr), .PorFlag(PorFlag)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sample takes 10 cycles from its rise edge to its result.
  // A rise while busy replaces the waiting sample, which starts as soon as the current result is out.
  logic [15:0] mRaw;
  int mSign, mH, mT, mO, mF, mAHi, mALo, mRng, mPor, mValid, mBusy;
  int tmr, pendV, first, prevUp;
  logic [15:0] cur, pend;

  task automatic model_result(input logic [15:0] r);
    int v, mg, ip, fr;
    v  = int'($signed(r));
    mg = (v < 0) ? -v : v;
    ip = mg / 16;
    fr = mg % 16;
    mRaw  = r;
    mSign = (v < 0) ? 1 : 0;
    mRng  = (mg >= 4096) ? 1 : 0;
    if (mRng != 0) begin
      mH = 9; mT = 9; mO = 9; mF = 9;
    end else begin
      mH = ip / 100; mT = (ip / 10) % 10; mO = ip % 10;
`ifdef TEMP_BCD_ROUND_EN
      mF = (fr * 10 + 8) / 16;
`else
      mF = (fr * 10) / 16;
`endif
    end
    mAHi = (v >= 1280) ? 1 : 0;
    mALo = (v <= -880) ? 1 : 0;
    mPor = (first != 0 && r == 16'h0550) ? 1 : 0;
    first = 0;
  endtask

  // Model step on every clock edge; async reset clears everything
  always @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      mRaw = '0; mSign = 0; mH = 0; mT = 0; mO = 0; mF = 0;
      mAHi = 0; mALo = 0; mRng = 0; mPor = 0; mValid = 0; mBusy = 0;
      tmr = 0; pendV = 0; first = 1; prevUp = 0; cur = '0; pend = '0;
    end else begin
      int riseNow;
      riseNow = (UpDate == 1'b1 && prevUp == 0) ? 1 : 0;
      prevUp  = (UpDate == 1'b1) ? 1 : 0;
      mValid  = 0;
      if (mBusy != 0) begin
        tmr--;
        if (tmr == 0) begin
          model_result(cur);
          mValid = 1;
          mBusy  = 0;
        end
      end
      if (riseNow != 0) begin
        if (mBusy != 0) begin
          pend = Data; pendV = 1;
        end else begin
          cur = Data; tmr = 10; mBusy = 1; pendV = 0;
        end
      end else if (mBusy == 0 && pendV != 0) begin
        cur = pend; tmr = 10; mBusy = 1; pendV = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge Clk) begin
    chk("Valid", int'(Valid), mValid);
    chk("Busy", int'(Busy), mBusy);
    chk("Raw", int'(Raw), int'(mRaw));
    chk("Sign", int'(Sign), mSign);
    chk("BcdHund", int'(BcdHund), mH);
    chk("BcdTens", int'(BcdTens), mT);
    chk("BcdOnes", int'(BcdOnes), mO);
    chk("BcdFrac", int'(BcdFrac), mF);
    chk("AlarmHi", int'(AlarmHi), mAHi);
    chk("AlarmLo", int'(AlarmLo), mALo);
    chk("RangeErr", int'(RangeErr), mRng);
    chk("PorFlag", int'(PorFlag), mPor);
  end

  task automatic pulse(input logic [15:0] d);
    @(negedge Clk);
    UpDate = 1'b1; Data = d; riseCyc = cyc + 1;
    @(negedge Clk);
    UpDate = 1'b0; Data = 16'($urandom);
  endtask

  task automatic waitValid(input string nm, input int expLat);
    int n;
    n = 0;
    @(negedge Clk);
    while (!Valid && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (!Valid) chk({nm, "_valid_timeout"}, 0, 1);
    else        chk({nm, "_latency"}, cyc - riseCyc, expLat);
  endtask

  task automatic chkOut(input string nm, input int s, input int h, input int t, input int o,
                        input int f, input int ahi, input int alo, input int rng, input int por);
    chk({nm, "_Sign"}, int'(Sign), s);
    chk({nm, "_Hund"}, int'(BcdHund), h);
    chk({nm, "_Tens"}, int'(BcdTens), t);
    chk({nm, "_Ones"}, int'(BcdOnes), o);
    chk({nm, "_Frac"}, int'(BcdFrac), f);
    chk({nm, "_AlarmHi"}, int'(AlarmHi), ahi);
    chk({nm, "_AlarmLo"}, int'(AlarmLo), alo);
    chk({nm, "_RangeErr"}, int'(RangeErr), rng);
    chk({nm, "_PorFlag"}, int'(PorFlag), por);
  endtask

  task automatic conv(input string nm, input logic [15:0] d);
    pulse(d);
    waitValid(nm, 10);
    chk({nm, "_Raw"}, int'(Raw), int'(d));
  endtask

  initial begin
    int vcnt, gap, len, sel;
    logic [15:0] d;
    logic [15:0] specials [8];
    specials[0] = 16'h0550; specials[1] = 16'h0500; specials[2] = 16'h04FF;
    specials[3] = 16'hFC90; specials[4] = 16'hFC91; specials[5] = 16'h8000;
    specials[6] = 16'h0FFF; specials[7] = 16'hF000;

    nRst = 1'b0; UpDate = 1'b0; Data = '0;
    repeat (3) @(negedge Clk);
    chk("rst_Raw", int'(Raw), 0);
    chk("rst_Valid", int'(Valid), 0);
    chk("rst_Busy", int'(Busy), 0);
    chkOut("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRst = 1'b1;

    // Power-on default value on the first sample, then again without the flag
    conv("por1", 16'h0550);
    chkOut("por1", 0, 0, 8, 5, 0, 1, 0, 0, 1);
    chk("por1_ValidOneCycle", int'(Valid), 1);
    @(negedge Clk);
    chk("por1_ValidDrops", int'(Valid), 0);
    chk("por1_Hold", int'(BcdTens), 8);
    conv("por2", 16'h0550);
    chkOut("por2", 0, 0, 8, 5, 0, 1, 0, 0, 0);

    conv("t1", 16'h0191);
    chkOut("t1", 0, 0, 2, 5, 0, 0, 0, 0, 0);
    conv("t2", 16'h0193);
`ifdef TEMP_BCD_ROUND_EN
    chkOut("t2", 0, 0, 2, 5, 2, 0, 0, 0, 0);
`else
    chkOut("t2", 0, 0, 2, 5, 1, 0, 0, 0, 0);
`endif
    conv("t3a", 16'hFF5E);
    chkOut("t3a", 1, 0, 1, 0, 1, 0, 0, 0, 0);
    conv("t3b", 16'hFC90);
    chkOut("t3b", 1, 0, 5, 5, 0, 0, 1, 0, 0);
    conv("lo_edge", 16'hFC91);
    chkOut("lo_edge", 1, 0, 5, 4, 9, 0, 0, 0, 0);
    conv("hi_edge", 16'h04FF);
    chkOut("hi_edge", 0, 0, 7, 9, 9, 0, 0, 0, 0);
    conv("t5a", 16'h1000);
    chkOut("t5a", 0, 9, 9, 9, 9, 1, 0, 1, 0);
    conv("t5b", 16'h8000);
    chkOut("t5b", 1, 9, 9, 9, 9, 0, 1, 1, 0);
    conv("max", 16'h0FFF);
    chkOut("max", 0, 2, 5, 5, 9, 1, 0, 0, 0);
    conv("negmax", 16'hF001);
    chkOut("negmax", 1, 2, 5, 5, 9, 0, 1, 0, 0);
    conv("negrng", 16'hF000);
    chkOut("negrng", 1, 9, 9, 9, 9, 0, 1, 1, 0);

    // Rises while busy: only the newest is kept, and it follows without an idle cycle
    @(negedge Clk); UpDate = 1'b1; Data = 16'h0190; riseCyc = cyc + 1;
    @(negedge Clk); UpDate = 1'b0;
    @(negedge Clk);
    @(negedge Clk); UpDate = 1'b1; Data = 16'h0320;
    @(negedge Clk); UpDate = 1'b0;
    @(negedge Clk); UpDate = 1'b1; Data = 16'h0040;
    @(negedge Clk); UpDate = 1'b0;
    waitValid("t6a", 10);
    chkOut("t6a", 0, 0, 2, 5, 0, 0, 0, 0, 0);
    chk("t6a_BusyStays", int'(Busy), 1);
    waitValid("t6b", 20);
    chkOut("t6b", 0, 0, 0, 4, 0, 0, 0, 0, 0);
    chk("t6b_Raw", int'(Raw), 16'h0040);

    // Reset in the middle of a conversion
    pulse(16'h0123);
    repeat (3) @(negedge Clk);
    #2 nRst = 1'b0;
    #1;
    chk("mid_rst_Raw", int'(Raw), 0);
    chk("mid_rst_Busy", int'(Busy), 0);
    chkOut("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk); nRst = 1'b1;
    vcnt = 0;
    repeat (15) begin
      @(negedge Clk);
      if (Valid) vcnt++;
    end
    chk("mid_rst_noValid", vcnt, 0);
    conv("por3", 16'h0550);
    chk("por3_PorFlag", int'(PorFlag), 1);

    // Randomized sample stream; the per-cycle model comparison does the checking
    for (int i = 0; i < 300; i++) begin
      gap = $urandom_range(0, 14);
      len = $urandom_range(1, 4);
      sel = $urandom_range(0, 3);
      case (sel)
        0: d = 16'($urandom);
        1: d = 16'($urandom_range(0, 8191) - 4096);
        2: d = specials[$urandom_range(0, 7)];
        default: d = 16'($urandom_range(0, 1400) - 700 + (($urandom_range(0, 1) != 0) ? 1280 : -880));
      endcase
      repeat (gap) begin
        @(negedge Clk);
        Data = 16'($urandom);
      end
      @(negedge Clk); UpDate = 1'b1; Data = d;
      repeat (len) @(negedge Clk);
      UpDate = 1'b0;
    end
    repeat (30) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
